// File: rtl/fft_pkg.sv
// Shared constants and sample/frame types for the 32-point real-input FFT
// datapath; used by the input framer and the FFT-side interface.
package fft_pkg;

  localparam int FFT_N  = 32;
  localparam int FFT_DW = 16;
  localparam int FFT_IW = $clog2(FFT_N);

  typedef logic signed [FFT_DW-1:0] sample_t;
  typedef sample_t [FFT_N-1:0]      frame_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One ping-pong bank: N samples written one at a time by index, read out
// as a whole frame in parallel, plus the full flag that gates its use.
module fft_frame_bank #(
  parameter int N  = fft_pkg::FFT_N,
  parameter int W  = fft_pkg::FFT_DW,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [W-1:0]    wr_data,
  input  logic            set_full,
  input  logic            clr_full,
  output logic            full,
  output logic [N*W-1:0]  rd_data
);

  logic [N-1:0][W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // The framer never sets and clears the same bank in one cycle: a bank
  // being completed is empty, a bank being drained is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-parallel framer in front of the FFT: assembles FFT_N samples
// into ping-pong banks and flags frames whose end marker is misplaced.
module fft_input_framer #(
  parameter int FFT_N  = fft_pkg::FFT_N,
  parameter int DATA_W = fft_pkg::FFT_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [FFT_N*DATA_W-1:0] frame_data,
  output logic                    frame_err
);

  localparam int IW = $clog2(FFT_N);

  logic [IW-1:0]           wr_idx;
  logic                    wr_bank;
  logic                    rd_bank;
  logic [1:0]              full;
  logic [FFT_N*DATA_W-1:0] bank_data [2];

  logic accept;
  logic drain;
  logic last_slot;
  logic complete;
  logic early_end;
  logic err_next;

  assign s_ready     = !full[wr_bank];
  assign accept      = s_valid && s_ready;
  assign frame_valid = full[rd_bank];
  assign drain       = frame_valid && frame_ready;
  assign last_slot   = (wr_idx == IW'(FFT_N - 1));
  assign complete    = accept && last_slot;
  assign early_end   = accept && s_last && !last_slot;
  assign err_next    = (complete && !s_last) || early_end;
  assign frame_data  = rd_bank ? bank_data[1] : bank_data[0];

  // An early end marker drops the partial frame by rewinding the index
  // while leaving wr_bank alone, so the bank is simply refilled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_next;
      if (accept) begin
        wr_idx <= (last_slot || s_last) ? '0 : wr_idx + 1'b1;
      end
      if (complete) begin
        wr_bank <= ~wr_bank;
      end
      if (drain) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .N  (FFT_N),
      .W  (DATA_W),
      .IW (IW)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept && (wr_bank == 1'(b))),
      .wr_idx   (wr_idx),
      .wr_data  (s_data),
      .set_full (complete && (wr_bank == 1'(b))),
      .clr_full (drain && (rd_bank == 1'(b))),
      .full     (full[b]),
      .rd_data  (bank_data[b])
    );
  end

endmodule

// File: tb/tb_fft_input_framer.sv
// Self-checking bench for fft_input_framer: a queue-based frame model is
// compared every cycle, plus hand-computed spot checks per scenario.
module tb_fft_input_framer;

  localparam int N  = fft_pkg::FFT_N;
  localparam int W  = fft_pkg::FFT_DW;
  localparam int FW = N * W;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic          frame_valid;
  logic          frame_ready;
  logic [FW-1:0] frame_data;
  logic          frame_err;

  int checks;
  int passes;

  fft_input_framer #(
    .FFT_N  (N),
    .DATA_W (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [FW-1:0] act,
                             input logic [FW-1:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: complete frames waiting for the FFT, oldest first, and the
  // partial frame being collected; only sample order matters here.
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] partial;
  int            part_cnt;
  logic          exp_err;

  initial begin
    partial  = '0;
    part_cnt = 0;
    exp_err  = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_s_ready", FW'(s_ready), FW'(1));
      checkOutput("rst_frame_valid", FW'(frame_valid), FW'(0));
      checkOutput("rst_frame_err", FW'(frame_err), FW'(0));
      exp_q.delete();
      partial  = '0;
      part_cnt = 0;
      exp_err  = 1'b0;
    end else begin
      logic acc;
      logic drn;
      checkOutput("s_ready", FW'(s_ready), FW'(exp_q.size() < 2));
      checkOutput("frame_valid", FW'(frame_valid), FW'(exp_q.size() > 0));
      if (exp_q.size() > 0) checkOutput("frame_data", frame_data, exp_q[0]);
      checkOutput("frame_err", FW'(frame_err), FW'(exp_err));
      acc     = s_valid && (exp_q.size() < 2);
      drn     = (exp_q.size() > 0) && frame_ready;
      exp_err = 1'b0;
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        partial[part_cnt*W +: W] = s_data;
        if (part_cnt == N - 1) begin
          exp_q.push_back(partial);
          exp_err  = !s_last;
          part_cnt = 0;
        end else if (s_last) begin
          exp_err  = 1'b1;
          part_cnt = 0;
        end else begin
          part_cnt++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that
  // accepted the sample, with s_valid still asserted.
  task automatic applyStimulus(input logic [W-1:0] data, input logic last);
    int   waited;
    logic rdy;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!rdy && waited < 100);
    if (!rdy) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] xk(input int k);
    return frame_data[k*W +: W];
  endfunction

  initial begin
    checks      = 0;
    passes      = 0;
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_data      = '0;
    s_last      = 1'b0;
    frame_ready = 1'b0;
    #1;
    checkOutput("init_s_ready", FW'(s_ready), FW'(1));
    checkOutput("init_frame_valid", FW'(frame_valid), FW'(0));
    checkOutput("init_frame_data", frame_data, FW'(0));
    checkOutput("init_frame_err", FW'(frame_err), FW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nextEdge();

    $display("[TB] continuous ramp");
    frame_ready = 1'b1;
    for (int i = 0; i < N; i++) applyStimulus(W'(i), i == N - 1);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("ramp_valid", FW'(frame_valid), FW'(1));
    checkOutput("ramp_x0", FW'(xk(0)), FW'(0));
    checkOutput("ramp_x17", FW'(xk(17)), FW'(17));
    checkOutput("ramp_x31", FW'(xk(31)), FW'(31));
    checkOutput("ramp_err", FW'(frame_err), FW'(0));
    nextEdge();
    idle(2);

    $display("[TB] backpressure");
    frame_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) applyStimulus(W'(i), (i % N) == N - 1);
    s_data = W'(64);
    s_last = 1'b0;
    @(negedge clk);
    checkOutput("bp_ready_low", FW'(s_ready), FW'(0));
    checkOutput("bp_x0_first", FW'(xk(0)), FW'(0));
    nextEdge();
    @(negedge clk);
    checkOutput("bp_ready_held_low", FW'(s_ready), FW'(0));
    nextEdge();
    s_valid     = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_x31_first", FW'(xk(31)), FW'(31));
    nextEdge();
    @(negedge clk);
    checkOutput("bp_x0_second", FW'(xk(0)), FW'(32));
    checkOutput("bp_x31_second", FW'(xk(31)), FW'(63));
    checkOutput("bp_ready_back", FW'(s_ready), FW'(1));
    nextEdge();
    idle(2);

    $display("[TB] early end marker");
    for (int i = 0; i < 10; i++) applyStimulus(W'(i + 40), i == 9);
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    checkOutput("early_err", FW'(frame_err), FW'(1));
    checkOutput("early_no_frame", FW'(frame_valid), FW'(0));
    nextEdge();
    @(negedge clk);
    checkOutput("early_err_one_cycle", FW'(frame_err), FW'(0));
    nextEdge();
    for (int i = 0; i < N; i++) applyStimulus(W'(100 + i), i == N - 1);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("early_next_valid", FW'(frame_valid), FW'(1));
    checkOutput("early_next_x0", FW'(xk(0)), FW'(100));
    checkOutput("early_next_x31", FW'(xk(31)), FW'(131));
    nextEdge();
    idle(2);

    $display("[TB] missing end marker");
    for (int i = 0; i < N; i++) applyStimulus(W'(200 + i), 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("miss_valid", FW'(frame_valid), FW'(1));
    checkOutput("miss_err", FW'(frame_err), FW'(1));
    checkOutput("miss_x5", FW'(xk(5)), FW'(205));
    nextEdge();
    idle(2);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 20; i++) applyStimulus(W'(300 + i), 1'b0);
    s_valid = 1'b0;
    rst     = 1'b1;
    #1;
    checkOutput("mid_rst_s_ready", FW'(s_ready), FW'(1));
    checkOutput("mid_rst_frame_valid", FW'(frame_valid), FW'(0));
    checkOutput("mid_rst_frame_data", frame_data, FW'(0));
    nextEdge();
    rst = 1'b0;
    nextEdge();
    for (int i = 0; i < N; i++) applyStimulus(W'(16'h7FFF - i), i == N - 1);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_x0", FW'(xk(0)), FW'(16'h7FFF));
    checkOutput("post_rst_x31", FW'(xk(31)), FW'(16'h7FE0));
    nextEdge();
    idle(2);

    $display("[TB] completion and drain in the same cycle");
    frame_ready = 1'b0;
    for (int i = 0; i < N; i++) applyStimulus(W'(16'h1000 + i), i == N - 1);
    for (int i = 0; i < N - 1; i++) applyStimulus(W'(16'h2000 + i), 1'b0);
    frame_ready = 1'b1;
    applyStimulus(W'(16'h201F), 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("simul_valid", FW'(frame_valid), FW'(1));
    checkOutput("simul_x0", FW'(xk(0)), FW'(16'h2000));
    checkOutput("simul_x31", FW'(xk(31)), FW'(16'h201F));
    checkOutput("simul_ready", FW'(s_ready), FW'(1));
    nextEdge();
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
